// File: rtl/l2_pkg.sv
// Shared constants, FSM state encoding and MAC table entry layout for the L2 forwarding engine.
package l2_pkg;

    localparam int MAC_W      = 48;
    localparam int BYTE_W     = 8;
    localparam int TYPE_W     = 16;
    localparam int HDR_W      = 2 * MAC_W + TYPE_W;
    localparam int HDR_BYTES  = HDR_W / BYTE_W;
    localparam int TYPE_LSB   = 0;
    localparam int SRC_LSB    = TYPE_LSB + TYPE_W;
    localparam int DST_LSB    = SRC_LSB + MAC_W;
    localparam int PORT_LSB   = DST_LSB + MAC_W;
    localparam int GROUP_BIT  = 40;
    localparam int PORT_W_MAX = 3;
    localparam int AGE_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_LEARN,
        ST_TX_HDR,
        ST_TX_PAY,
        ST_DROP,
        ST_POP
    } state_e;

    // Port is stored at the widest legal width; narrower configs zero-extend.
    typedef struct packed {
        logic                  valid;
        logic [MAC_W-1:0]      mac;
        logic [PORT_W_MAX-1:0] port;
        logic [AGE_W-1:0]      age;
    } mac_entry_t;

    // Byte idx of the header on the wire, DST MSB first.
    function automatic logic [BYTE_W-1:0] hdr_byte(input logic [HDR_W-1:0] hdr,
                                                   input logic [3:0]       idx);
        logic [HDR_W-1:0] sh;
        sh = hdr << (BYTE_W * idx);
        return sh[HDR_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/l2_mac_table.sv
// Shared MAC table: parallel SRC/DST compare, victim selection, aging, refresh and learn write port.
module l2_mac_table
    import l2_pkg::*;
#(
    parameter int TBL_AW  = 5,
    parameter int AGE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MAC_W-1:0]      src_mac_i,
    input  logic [MAC_W-1:0]      dst_mac_i,
    input  logic [PORT_W_MAX-1:0] in_port_i,
    input  logic                  cmp_en_i,
    input  logic                  refresh_en_i,
    input  logic                  learn_en_i,
    input  logic                  age_tick_i,
    output logic                  src_hit_o,
    output logic                  dst_hit_o,
    output logic [PORT_W_MAX-1:0] dst_port_o
);

    localparam int DEPTH = 2 ** TBL_AW;

    mac_entry_t tbl_q [DEPTH];
    mac_entry_t tbl_d [DEPTH];

    logic                  src_hit_c, dst_hit_c, vic_found;
    logic [TBL_AW-1:0]     src_idx_c, vic_c;
    logic [PORT_W_MAX-1:0] dst_port_c;
    logic [AGE_W-1:0]      vic_age;

    logic                  src_hit_q, dst_hit_q;
    logic [TBL_AW-1:0]     src_idx_q, victim_q;
    logic [PORT_W_MAX-1:0] dst_port_q;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        src_hit_c  = 1'b0;
        src_idx_c  = '0;
        dst_hit_c  = 1'b0;
        dst_port_c = '0;
        vic_found  = 1'b0;
        vic_c      = '0;
        vic_age    = tbl_q[0].age;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_q[i].valid && (tbl_q[i].mac == src_mac_i) && !src_hit_c) begin
                src_hit_c = 1'b1;
                src_idx_c = TBL_AW'(i);
            end
            if (tbl_q[i].valid && (tbl_q[i].mac == dst_mac_i) && !dst_hit_c) begin
                dst_hit_c  = 1'b1;
                dst_port_c = tbl_q[i].port;
            end
            if (!tbl_q[i].valid && !vic_found) begin
                vic_found = 1'b1;
                vic_c     = TBL_AW'(i);
            end
        end
        // Full table: oldest entry, strict compare keeps the lowest index on ties.
        if (!vic_found) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (tbl_q[i].age > vic_age) begin
                    vic_age = tbl_q[i].age;
                    vic_c   = TBL_AW'(i);
                end
            end
        end
    end

    // Aging first, then refresh/learn override it on the same entry.
    always_comb begin
        tbl_d = tbl_q;
        if (age_tick_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tbl_q[i].valid) begin
                    if (tbl_q[i].age < AGE_W'(AGE_MAX)) begin
                        tbl_d[i].age = tbl_q[i].age + AGE_W'(1);
                    end else begin
                        tbl_d[i].valid = 1'b0;
                        tbl_d[i].age   = '0;
                    end
                end
            end
        end
        if (refresh_en_i) begin
            tbl_d[src_idx_q].valid = 1'b1;
            tbl_d[src_idx_q].port  = in_port_i;
            tbl_d[src_idx_q].age   = '0;
        end
        if (learn_en_i) begin
            tbl_d[victim_q] = '{valid: 1'b1, mac: src_mac_i, port: in_port_i, age: '0};
        end
    end

    // NOTE: the table is flop-based and must be cleared on reset, so it is not mapped to RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_q <= '{default: '0};
        end else begin
            tbl_q <= tbl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_hit_q  <= 1'b0;
            src_idx_q  <= '0;
            dst_hit_q  <= 1'b0;
            dst_port_q <= '0;
            victim_q   <= '0;
        end else if (cmp_en_i) begin
            src_hit_q  <= src_hit_c;
            src_idx_q  <= src_idx_c;
            dst_hit_q  <= dst_hit_c;
            dst_port_q <= dst_port_c;
            victim_q   <= vic_c;
        end
    end

    assign src_hit_o  = src_hit_q;
    assign dst_hit_o  = dst_hit_q;
    assign dst_port_o = dst_port_q;

endmodule

// File: rtl/l2_fwd_engine.sv
// L2 forwarding engine: header/payload FWFT consumer, MAC lookup/learn and per-port egress writer.
module l2_fwd_engine
    import l2_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int TBL_AW    = 5,
    parameter  int AGE_MAX   = 3,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PW+HDR_W-1:0]   hdr_dout,
    input  logic                  hdr_empty,
    output logic                  hdr_rden,
    input  logic [BYTE_W-1:0]     pay_dout,
    input  logic                  pay_last,
    input  logic                  pay_empty,
    output logic                  pay_rden,
    input  logic                  age_tick,
    output logic [BYTE_W-1:0]     out_data,
    output logic [NUM_PORTS-1:0]  out_wren,
    input  logic [NUM_PORTS-1:0]  out_afull,
    output logic [15:0]           drop_cnt
);

    state_e               state_q, state_d;
    logic                 lk_q, lk_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] mask_q, mask_d;
    logic [BYTE_W-1:0]    out_data_q, out_data_d;
    logic [NUM_PORTS-1:0] out_wren_q, out_wren_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic                  hdr_pop, pay_pop, cmp_en, refresh_en, learn_en;
    logic                  src_hit, dst_hit;
    logic [PORT_W_MAX-1:0] dst_port, in_port;
    logic [MAC_W-1:0]      src_mac, dst_mac;
    logic [NUM_PORTS-1:0]  in_onehot, base_mask, fwd_mask;

    assign in_port = PORT_W_MAX'(hdr_dout[PORT_LSB +: PW]);
    assign dst_mac = hdr_dout[DST_LSB +: MAC_W];
    assign src_mac = hdr_dout[SRC_LSB +: MAC_W];

    // Ingress port is excluded from both flood and unicast, so a hairpin unicast drops.
    assign in_onehot = NUM_PORTS'(1) << in_port;
    assign base_mask = (dst_mac[GROUP_BIT] || !dst_hit) ? ~in_onehot : (NUM_PORTS'(1) << dst_port);
    assign fwd_mask  = base_mask & ~in_onehot & ~out_afull;

    l2_mac_table #(
        .TBL_AW (TBL_AW),
        .AGE_MAX(AGE_MAX)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_mac_i   (src_mac),
        .dst_mac_i   (dst_mac),
        .in_port_i   (in_port),
        .cmp_en_i    (cmp_en),
        .refresh_en_i(refresh_en),
        .learn_en_i  (learn_en),
        .age_tick_i  (age_tick),
        .src_hit_o   (src_hit),
        .dst_hit_o   (dst_hit),
        .dst_port_o  (dst_port)
    );

    always_comb begin
        state_d    = state_q;
        lk_d       = 1'b0;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        out_data_d = out_data_q;
        out_wren_d = '0;
        drop_cnt_d = drop_cnt_q;
        hdr_pop    = 1'b0;
        pay_pop    = 1'b0;
        cmp_en     = 1'b0;
        refresh_en = 1'b0;
        learn_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!hdr_empty) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (!lk_q) begin
                    cmp_en = 1'b1;
                    lk_d   = 1'b1;
                end else begin
                    refresh_en = src_hit;
                    mask_d     = fwd_mask;
                    cnt_d      = '0;
                    if (!src_hit)           state_d = ST_LEARN;
                    else if (fwd_mask == '0) state_d = ST_DROP;
                    else                    state_d = ST_TX_HDR;
                end
            end
            ST_LEARN: begin
                learn_en = 1'b1;
                state_d  = (mask_q == '0) ? ST_DROP : ST_TX_HDR;
            end
            ST_TX_HDR: begin
                out_data_d = hdr_byte(hdr_dout[TYPE_LSB +: HDR_W], cnt_q);
                out_wren_d = mask_q;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == 4'(HDR_BYTES - 1)) state_d = ST_TX_PAY;
            end
            ST_TX_PAY: begin
                if (!pay_empty) begin
                    pay_pop    = 1'b1;
                    out_data_d = pay_dout;
                    out_wren_d = mask_q;
                    if (pay_last) state_d = ST_POP;
                end
            end
            ST_DROP: begin
                if (!pay_empty) begin
                    pay_pop = 1'b1;
                    if (pay_last) begin
                        state_d = ST_POP;
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
            ST_POP: begin
                hdr_pop = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lk_q       <= 1'b0;
            cnt_q      <= '0;
            mask_q     <= '0;
            out_data_q <= '0;
            out_wren_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lk_q       <= lk_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            out_data_q <= out_data_d;
            out_wren_q <= out_wren_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Pops are masked while reset is held so an abandoned frame loses no more FIFO data.
    assign hdr_rden = hdr_pop & rst_n;
    assign pay_rden = pay_pop & rst_n;
    assign out_data = out_data_q;
    assign out_wren = out_wren_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/l2_fwd_engine.md
L2_FWD_ENGINE -- requirements
Module: l2_fwd_engine

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of switch ports, legal range 2..8.
REQ-002 Parameter TBL_AW, default 5: MAC table address width, giving 2**TBL_AW entries shared by all ports.
REQ-003 Parameter AGE_MAX, default 3: age count at which an entry expires, legal range 1..15.
REQ-004 Port list, one per line: name, direction, width, meaning; clock and reset first.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- hdr_dout  in  PW+112  {ingress port, DST MAC, SRC MAC, TYPE}, where PW = clog2(NUM_PORTS); first-word-fall-through (FWFT).
- hdr_empty  in  1  header FIFO empty.
- hdr_rden  out  1  header pop, one cycle per frame.
- pay_dout  in  8  payload byte, FWFT.
- pay_last  in  1  marks the current pay_dout as the last byte of the frame.
- pay_empty  in  1  payload FIFO empty.
- pay_rden  out  1  payload pop.
- age_tick  in  1  single-cycle aging strobe.
- out_data  out  8  egress byte, registered.
- out_wren  out  NUM_PORTS  per-port egress write enable, registered.
- out_afull  in  NUM_PORTS  per-port egress almost-full.
- drop_cnt  out  16  saturating count of dropped frames.

Function
REQ-005 States: IDLE, LOOKUP, LEARN, TX_HDR, TX_PAY, DROP, POP.
REQ-006 IDLE moves to LOOKUP when hdr_empty=0.
REQ-007 LOOKUP lasts exactly 2 cycles:
- cycle 1: SRC and DST are compared against all valid entries in parallel.
- cycle 2: the registered results are used.
REQ-008 SRC hit, same port: age reset to 0, no write.
REQ-009 SRC hit, different port: the entry's port field is rewritten (station move) and age reset to 0.
REQ-010 SRC miss: go to LEARN, which writes {valid, SRC, port, age 0} in 1 cycle.
REQ-011 LEARN victim selection: the lowest-index invalid entry; if the table is full, the entry with the highest age, lowest index on ties.
REQ-012 Egress mask:
- DST[40]=1 (group address) or DST miss: flood, all ports except the ingress port.
- DST hit: one-hot of the stored port.
REQ-013 The egress mask is ANDed with ~out_afull, sampled once in LOOKUP cycle 2 and then frozen for the whole frame.
REQ-014 An empty final mask (including a unicast hit on the ingress port) sends the frame to DROP; otherwise to TX_HDR.
REQ-015 TX_HDR emits 14 bytes in order: DST MSB first, then SRC, then TYPE, one byte per cycle, with out_wren = mask on each.
REQ-016 TX_PAY:
- pay_rden = ~pay_empty.
- Each popped byte appears on out_data one cycle later with out_wren = mask.
- If pay_empty, out_wren = 0 and the state holds.
REQ-017 Popping the byte with pay_last=1 moves the state to POP after that byte is written.
REQ-018 DROP pops payload bytes with no out_wren until the pay_last byte, then goes to POP and increments drop_cnt, saturating at 0xFFFF.
REQ-019 POP asserts hdr_rden for 1 cycle, then returns to IDLE.
REQ-020 An age_tick in any state increments the age of every valid entry that is below AGE_MAX.
- An entry already at AGE_MAX is invalidated.
- On the same cycle as a hit refresh, the refresh wins.
REQ-021 A frame whose SRC was learned in LEARN is available for DST lookup of the next frame (no bypass within the same frame).

Reset
REQ-022 While rst_n=0 at a clk edge:
- All table entries are invalid, all ages 0.
- State is IDLE; drop_cnt = 0.
- hdr_rden, pay_rden, out_wren = 0; out_data = 0.
REQ-023 Reset mid-frame abandons the frame with no further pops or writes; the upstream FIFOs are reset by the same rst_n.

Structure
REQ-024 Shared package l2_pkg holds:
- the MAC width constant (48), the header field offsets, and the byte width (8);
- the state enum;
- the table entry typedef {valid, mac[47:0], port[PW-1:0], age[3:0]}.
REQ-025 Sub-module l2_mac_table holds the entries, the parallel compare, victim selection, aging and the write port; l2_fwd_engine holds the FSM and the datapath.

Verification
REQ-026 After reset, frame on port 0 with SRC 02:00:00:00:00:0A, DST 02:00:00:00:00:0B (miss): 14+N bytes on ports 1,2,3, none on port 0; SRC learned on port 0.
REQ-027 A following frame on port 2 with DST 02:00:00:00:00:0A: out_wren = 4'b0001 only; SRC of that frame learned on port 2.
REQ-028 Frame with DST FF:FF:FF:FF:FF:FF from port 1 while out_afull = 4'b0100: out_wren = 4'b1001; a frame with all eligible ports afull raises drop_cnt from 0 to 1 and fully consumes its payload.
REQ-029 SRC 02:00:00:00:00:0A re-seen on port 3: entry moves; the next unicast to it goes to port 3 only.
REQ-030 AGE_MAX=3, four age_tick pulses with no traffic: the entry is invalidated and the next frame to it floods; a table filled with 32 SRCs plus a 33rd replaces the oldest entry.
REQ-031 pay_empty toggled every other cycle: output bytes are contiguous in order with gaps; rst_n low mid-payload gives out_wren = 0 on the next cycle and IDLE.
